// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: state encoding and timing defaults shared by the stopwatch control and digit counters
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, LAP = 2'd3} sw_state_e;
  localparam int TICK_DIV_DEFAULT = 2_500_000;
  localparam int LOCKOUT_CYCLES_DEFAULT = 250_000;
endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: two-flop synchronizer for a raw button followed by a registered rising-edge pulse
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);
  logic s1_q, s2_q, prev_q, rise_q, rise_d;
  always_comb rise_d = s2_q & ~prev_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q <= btn;
      s2_q <= s1_q;
      prev_q <= s2_q;
      rise_q <= rise_d;
    end
  end
  assign rise = rise_q;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button-driven FSM, press lockout and 0.1 s prescaler sequencing the digit counters
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic       tick,
  output logic       clear_cnt,
  output logic       hold_display,
  output logic       running,
  output logic [1:0] state
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [LW-1:0] LMAX = LW'(LOCKOUT_CYCLES);
  logic ev_ss, ev_lap, ev_clr;
  btn_sync_edge u_ss  (.clk(clk), .reset(reset), .btn(btn_start_stop), .rise(ev_ss));
  btn_sync_edge u_lap (.clk(clk), .reset(reset), .btn(btn_lap),        .rise(ev_lap));
  btn_sync_edge u_clr (.clk(clk), .reset(reset), .btn(btn_clear),      .rise(ev_clr));
  sw_state_e state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [LW-1:0] lock_q, lock_d;
  logic tick_q, tick_d, clr_q, clr_d, hold_q, hold_d, run_q, run_d;
  logic run_now, free, acc_ss, acc_lap, acc_clr;
  // Only events that change behaviour in the current state are accepted and arm the lockout.
  always_comb begin
    run_now = (state_q == RUN) || (state_q == LAP);
    free = (lock_q == '0);
    acc_ss = free && ev_ss;
    acc_lap = free && !ev_ss && ev_lap && run_now;
    acc_clr = free && !ev_ss && ev_clr && !run_now;
    state_d = acc_ss ? (run_now ? PAUSE : RUN) :
              acc_lap ? ((state_q == LAP) ? RUN : LAP) :
              acc_clr ? IDLE : state_q;
    lock_d = (acc_ss || acc_lap || acc_clr) ? LMAX : free ? '0 : lock_q - 1'b1;
    tick_d = run_now && (pre_q == PMAX);
    pre_d = acc_clr ? '0 : !run_now ? pre_q : tick_d ? '0 : pre_q + 1'b1;
    clr_d = acc_clr;
    hold_d = (state_d == LAP);
    run_d = (state_d == RUN) || (state_d == LAP);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pre_q <= '0;
      lock_q <= '0;
      tick_q <= 1'b0;
      clr_q <= 1'b0;
      hold_q <= 1'b0;
      run_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q <= pre_d;
      lock_q <= lock_d;
      tick_q <= tick_d;
      clr_q <= clr_d;
      hold_q <= hold_d;
      run_q <= run_d;
    end
  end
  assign tick = tick_q;
  assign clear_cnt = clr_q;
  assign hold_display = hold_q;
  assign running = run_q;
  assign state = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed and random button sequences checked every cycle against a rule-level model
module tb_stopwatch_ctrl;
  localparam int TD = 4;
  localparam int LK = 3;
  logic clk = 1'b0, reset = 1'b0;
  logic b_ss = 1'b0, b_lap = 1'b0, b_clr = 1'b0;
  logic tick, clear_cnt, hold_display, running;
  logic [1:0] state;
  int n_chk = 0, n_fail = 0;
  logic [4:0] h_ss, h_lap, h_clr;
  int k, last_acc, run_cnt, m_st;
  logic m_tick, m_clr;

  stopwatch_ctrl #(.TICK_DIV(TD), .LOCKOUT_CYCLES(LK)) dut (
    .clk(clk), .reset(reset), .btn_start_stop(b_ss), .btn_lap(b_lap), .btn_clear(b_clr),
    .tick(tick), .clear_cnt(clear_cnt), .hold_display(hold_display), .running(running), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, got, exp, k);
    end
  endtask

  task automatic model_reset();
    h_ss = '0; h_lap = '0; h_clr = '0;
    k = 0; last_acc = -100; run_cnt = 0; m_st = 0; m_tick = 0; m_clr = 0;
  endtask

  // A press seen at edge k-3 with the button low at edge k-4 is acted on at edge k;
  // ticks fall on every TD-th edge spent running since the last clear.
  task automatic step();
    bit e_ss, e_lap, e_clr, run_b;
    @(posedge clk);
    k++;
    h_ss = {h_ss[3:0], b_ss};
    h_lap = {h_lap[3:0], b_lap};
    h_clr = {h_clr[3:0], b_clr};
    e_ss = h_ss[3] & ~h_ss[4];
    e_lap = h_lap[3] & ~h_lap[4];
    e_clr = h_clr[3] & ~h_clr[4];
    run_b = (m_st == 1) || (m_st == 3);
    m_tick = 0;
    m_clr = 0;
    if (run_b) begin
      run_cnt++;
      m_tick = (run_cnt % TD == 0);
    end
    if (k - last_acc > LK) begin
      if (e_ss) begin
        m_st = run_b ? 2 : 1; last_acc = k;
      end else if (e_lap && run_b) begin
        m_st = (m_st == 3) ? 1 : 3; last_acc = k;
      end else if (e_clr && !run_b) begin
        m_st = 0; m_clr = 1; run_cnt = 0; last_acc = k;
      end
    end
    #1;
    chk("state", state, m_st);
    chk("tick", tick, m_tick);
    chk("clear_cnt", clear_cnt, m_clr);
    chk("hold_display", hold_display, m_st == 3);
    chk("running", running, (m_st == 1) || (m_st == 3));
  endtask

  task automatic press(input bit s, input bit l, input bit c, input int gap);
    b_ss = s; b_lap = l; b_clr = c;
    step();
    b_ss = 0; b_lap = 0; b_clr = 0;
    repeat (gap) step();
  endtask

  initial begin
    model_reset();
    #11;
    chk("rst_state", state, 0);
    chk("rst_tick", tick, 0);
    chk("rst_running", running, 0);
    reset = 1'b1;
    repeat (4) step();
    chk("idle_state", state, 0);
    press(1, 0, 0, 14);
    press(1, 0, 0, 6);
    chk("paused", state, 2);
    press(1, 0, 0, 12);
    press(0, 1, 0, 10);
    chk("lap_hold", hold_display, 1);
    press(0, 1, 0, 10);
    chk("lap_release", hold_display, 0);
    press(1, 0, 0, 6);
    press(0, 0, 1, 6);
    chk("cleared_idle", state, 0);
    press(1, 0, 0, 6);
    press(0, 0, 1, 0);
    press(1, 0, 0, 8);
    chk("clear_in_run_no_lock", state, 2);
    press(1, 0, 0, 8);
    press(1, 1, 0, 1);
    press(1, 0, 0, 1);
    press(1, 0, 0, 10);
    chk("lockout_resume", state, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_state", state, 0);
    chk("async_tick", tick, 0);
    chk("async_clear", clear_cnt, 0);
    chk("async_hold", hold_display, 0);
    chk("async_running", running, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (8) step();
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 4))
        0: press(1, 0, 0, $urandom_range(0, 12));
        1: press(0, 1, 0, $urandom_range(0, 12));
        2: press(0, 0, 1, $urandom_range(0, 12));
        3: press(1, 1, 0, $urandom_range(0, 12));
        default: press(1, 0, 1, $urandom_range(0, 12));
      endcase
    end
    repeat (10) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM for the stopwatch digit chain. It takes the start/stop, lap and clear push-buttons and owns the 0.1 s prescaler. It drives the tenths/seconds counters with a one-cycle count-enable tick, a one-cycle clear pulse and a display-hold level. The digit counters become pure enabled counters, and all sequencing lives here.

Parameters:
TICK_DIV, 2_500_000, clk cycles per tick pulse (0.1 s at 25 MHz); must be >= 2.
LOCKOUT_CYCLES, 250_000, cycles for which all buttons are ignored after an accepted press (debounce); must be >= 1.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset; 0 resets the block
btn_start_stop  in  1  raw asynchronous button, active-high
btn_lap  in  1  raw asynchronous button, active-high
btn_clear  in  1  raw asynchronous button, active-high
tick  out  1  one-cycle count enable for the tenths counter
clear_cnt  out  1  one-cycle synchronous clear for all digit counters
hold_display  out  1  level; 1 = display latches keep the frozen lap value
running  out  1  level; 1 in RUN or LAP
state  out  2  current FSM state encoding

Behaviour:
- Reset (reset=0, async): state=IDLE, tick=0, clear_cnt=0, hold_display=0, running=0, prescaler=0, lockout counter=0, synchronizer and edge flops=0.
- Button path, per button:
  - 2-flop synchronizer, then a rising-edge detect (sync high, previous sync low).
  - A press that is high at rising edge N produces an edge event in the cycle after edge N+2. The FSM acts on it at edge N+3.
- Lockout:
  - An accepted event loads the lockout counter with LOCKOUT_CYCLES.
  - While the counter is nonzero, all edge events are discarded and the counter decrements each cycle.
  - An event is accepted only when the counter is 0.
- Simultaneous events: at most one event is accepted per cycle. Priority is start_stop > lap > clear; lower-priority events in that cycle are dropped.
- States and encoding: IDLE=0, RUN=1, PAUSE=2, LAP=3.
  - IDLE: start_stop -> RUN. lap is ignored. clear stays in IDLE and still pulses clear_cnt.
  - RUN: start_stop -> PAUSE. lap -> LAP. clear is ignored and not accepted, so it does not start the lockout.
  - LAP: lap -> RUN (display released). start_stop -> PAUSE (display released). clear is ignored.
  - PAUSE: start_stop -> RUN. clear -> IDLE. lap is ignored.
  - Ignored events do not load the lockout counter.
- Output decode:
  - running = (state==RUN or state==LAP).
  - hold_display = (state==LAP), registered together with the state.
- clear_cnt:
  - Registered, high for exactly one cycle, in the cycle after the clear event is accepted in IDLE or PAUSE.
  - The same edge resets the prescaler to 0.
- Prescaler:
  - Width $clog2(TICK_DIV).
  - Increments only while running; holds its value in PAUSE, so phase is preserved across a pause.
  - Wraps TICK_DIV-1 -> 0.
  - tick is registered and is 1 for the cycle after the prescaler value TICK_DIV-1 is sampled while running.
  - Tick period is exactly TICK_DIV cycles while running continuously.
- Stop at the wrap edge: if the FSM leaves RUN/LAP on the same edge the prescaler wraps, that tick still issues. No further ticks follow until running again.
- Reset mid-operation: all state is lost immediately, and outputs go to their reset values asynchronously.

Decomposition:
- stopwatch_pkg holds:
  - state encoding constants IDLE/RUN/PAUSE/LAP (2-bit typedef);
  - default TICK_DIV and LOCKOUT_CYCLES constants, shared with the digit counters.
- Sub-module btn_sync_edge (2-flop sync + rising-edge detect), instantiated 3 times.
- The lockout counter, FSM and prescaler stay in stopwatch_ctrl.

Test Plan (TICK_DIV=4, LOCKOUT_CYCLES=3):
1. Reset: drive reset=0 mid-run -> all outputs 0 immediately; after release, state=0 and no ticks.
2. Start: pulse start_stop high at edge N -> state=1 at edge N+3; tick at cycles N+7, N+11, N+15 (period 4).
3. Pause and resume: press start_stop while the prescaler=2 -> state=2 and ticks stop. Press again -> state=1; the first tick arrives 2 cycles after resume (phase held).
4. Lap: in RUN press lap -> state=3, hold_display=1, ticks continue. Press lap again -> state=1, hold_display=0.
5. Clear: in PAUSE press clear -> clear_cnt high for exactly 1 cycle, state=0, prescaler=0. Press clear in RUN -> no clear_cnt, and an immediately following start_stop is accepted (no lockout).
6. Priority and lockout: start_stop and lap rise in the same cycle in RUN -> state=2 only. A second start_stop edge 2 cycles later is dropped. A third edge after 3 cycles of lockout -> state=1.
